// File: rtl/odometer_seq_ctrl_if.sv
// rtl/odometer_seq_ctrl_if.sv - command/result channel between test controller and odometer sequencer
interface odometer_seq_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 24
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_meas;
  logic [1:0]       cmd_sel;
  logic             cmd_ac;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             cmd_err;
  logic             result_valid;
  logic             result_ack;
  logic [CNT_W-1:0] result_count;
  logic [1:0]       result_sel;
  logic             result_ovf;

  modport master (
    output cmd_valid, cmd_meas, cmd_sel, cmd_ac, cmd_len, abort, result_ack,
    input  cmd_ready, cmd_err, result_valid, result_count, result_sel, result_ovf
  );

  modport slave (
    input  cmd_valid, cmd_meas, cmd_sel, cmd_ac, cmd_len, abort, result_ack,
    output cmd_ready, cmd_err, result_valid, result_count, result_sel, result_ovf
  );
endinterface

// File: rtl/odometer_seq_ctrl.sv
// rtl/odometer_seq_ctrl.sv - safe power/enable/start sequencer and edge counter for one odometer block
module odometer_seq_ctrl #(
  parameter int CNT_W  = 16,
  parameter int LEN_W  = 24,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  odometer_seq_ctrl_if.slave   bus,
  input  logic                 rosc_out,
  output logic                 sel_inv97,
  output logic                 sel_inv99,
  output logic                 sel_inv101,
  output logic                 en_power_rosc,
  output logic                 en_rosc,
  output logic                 start,
  output logic                 meas_stress,
  output logic                 ac_dc,
  output logic                 ac_stress_clk
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ARM, S_RUN, S_DRAIN, S_RESULT
  } state_t;

  // Macro control bundle, kept together so every exit to idle clears it in one assignment.
  typedef struct packed {
    logic sel97;
    logic sel99;
    logic sel101;
    logic en_power;
    logic en_rosc;
    logic start;
    logic meas_stress;
    logic ac_dc;
    logic ac_clk;
  } ctl_t;

  localparam logic [LEN_W-1:0] SETTLE_LAST = LEN_W'(SETTLE - 1);
  localparam logic [LEN_W-1:0] DRAIN_LAST  = LEN_W'(2);

  state_t            state_q;
  ctl_t              ctl_q;
  logic              ready_q;
  logic              err_q;
  logic              valid_q;
  logic [1:0]        sel_q;
  logic              meas_q;
  logic              ac_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  dur_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise;
  logic              active;

  // Two-flop synchronizer plus a delay stage for rising-edge detection of the ring output.
  always_comb begin
    sync_d = {sync_q[0], rosc_out};
    prev_d = sync_q[1];
    rise   = sync_q[1] & ~prev_q;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge counter: cleared in ARM, counts through RUN and DRAIN, sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_ARM) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if ((state_q == S_RUN || state_q == S_DRAIN) && rise) begin
      if (cnt_q == '1) ovf_d = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign active = (state_q == S_SETUP) || (state_q == S_ARM) ||
                  (state_q == S_RUN)   || (state_q == S_DRAIN);

  // Sequencer FSM with registered macro controls and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      meas_q  <= 1'b0;
      ac_q    <= 1'b0;
      len_q   <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (bus.abort && active) begin
        state_q <= S_IDLE;
        ctl_q   <= '0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.cmd_valid) begin
              if (bus.cmd_sel == 2'd3) begin
                err_q <= 1'b1;
              end else begin
                state_q           <= S_SETUP;
                ready_q           <= 1'b0;
                sel_q             <= bus.cmd_sel;
                meas_q            <= bus.cmd_meas;
                ac_q              <= bus.cmd_ac;
                len_q             <= (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                dur_q             <= '0;
                ctl_q.en_power    <= 1'b1;
                ctl_q.sel97       <= (bus.cmd_sel == 2'd0);
                ctl_q.sel99       <= (bus.cmd_sel == 2'd1);
                ctl_q.sel101      <= (bus.cmd_sel == 2'd2);
                ctl_q.meas_stress <= bus.cmd_meas;
                ctl_q.ac_dc       <= bus.cmd_ac & ~bus.cmd_meas;
              end
            end
          end
          S_SETUP: begin
            if (dur_q == SETTLE_LAST) begin
              state_q       <= S_ARM;
              ctl_q.en_rosc <= 1'b1;
              dur_q         <= '0;
            end else begin
              dur_q <= dur_q + LEN_W'(1);
            end
          end
          S_ARM: begin
            state_q      <= S_RUN;
            ctl_q.start  <= 1'b1;
            ctl_q.ac_clk <= ac_q & ~meas_q;
            dur_q        <= '0;
          end
          S_RUN: begin
            if (dur_q == len_q - LEN_W'(1)) begin
              dur_q <= '0;
              if (meas_q) begin
                state_q       <= S_DRAIN;
                ctl_q.start   <= 1'b0;
                ctl_q.en_rosc <= 1'b0;
                ctl_q.ac_clk  <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                ctl_q   <= '0;
                ready_q <= 1'b1;
              end
            end else begin
              dur_q        <= dur_q + LEN_W'(1);
              ctl_q.ac_clk <= ctl_q.ac_clk ^ (ac_q & ~meas_q);
            end
          end
          S_DRAIN: begin
            if (dur_q == DRAIN_LAST) begin
              state_q <= S_RESULT;
              ctl_q   <= '0;
              valid_q <= 1'b1;
            end else begin
              dur_q <= dur_q + LEN_W'(1);
            end
          end
          S_RESULT: begin
            if (bus.result_ack) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.cmd_err      = err_q;
  assign bus.result_valid = valid_q;
  assign bus.result_count = cnt_q;
  assign bus.result_sel   = sel_q;
  assign bus.result_ovf   = ovf_q;

  assign sel_inv97     = ctl_q.sel97;
  assign sel_inv99     = ctl_q.sel99;
  assign sel_inv101    = ctl_q.sel101;
  assign en_power_rosc = ctl_q.en_power;
  assign en_rosc       = ctl_q.en_rosc;
  assign start         = ctl_q.start;
  assign meas_stress   = ctl_q.meas_stress;
  assign ac_dc         = ctl_q.ac_dc;
  assign ac_stress_clk = ctl_q.ac_clk;

endmodule

// File: tb/tb_odometer_seq_ctrl.sv
// tb/tb_odometer_seq_ctrl.sv - scoreboard bench for the odometer sequencer
module tb_odometer_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  odometer_seq_ctrl_if #(.CNT_W(16), .LEN_W(24)) bus ();
  odometer_seq_ctrl_if #(.CNT_W(4),  .LEN_W(24)) bus4 ();

  logic s97, s99, s101, pw, er, st, ms, ad, ac;
  logic t97, t99, t101, tpw, ter, tst, tms, tad, tac;
  logic rosc = 1'b0;
  logic rosc4 = 1'b0;
  int   ph = 0;
  int   ph4 = 0;

  odometer_seq_ctrl #(.CNT_W(16), .LEN_W(24), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rosc_out(rosc),
    .sel_inv97(s97), .sel_inv99(s99), .sel_inv101(s101), .en_power_rosc(pw),
    .en_rosc(er), .start(st), .meas_stress(ms), .ac_dc(ad), .ac_stress_clk(ac)
  );

  odometer_seq_ctrl #(.CNT_W(4), .LEN_W(24), .SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .rosc_out(rosc4),
    .sel_inv97(t97), .sel_inv99(t99), .sel_inv101(t101), .en_power_rosc(tpw),
    .en_rosc(ter), .start(tst), .meas_stress(tms), .ac_dc(tad), .ac_stress_clk(tac)
  );

  // Ring models: oscillate only while START is high (period 8 and period 4 CLK).
  always @(negedge clk) begin
    if (st) begin ph = ph + 1; rosc = ph[2]; end
    else    begin ph = 0; rosc = 1'b0; end
  end
  always @(negedge clk) begin
    if (tst) begin ph4 = ph4 + 1; rosc4 = ph4[1]; end
    else     begin ph4 = 0; rosc4 = 1'b0; end
  end

  typedef struct {
    logic [1:0] sel;
    int         cmin;
    int         cmax;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] ctl_main();
    return {s97, s99, s101, pw, er, st, ms, ad, ac};
  endfunction

  task automatic issue(input logic meas, input logic [1:0] sel, input logic acm, input logic [23:0] len);
    @(negedge clk);
    bus.cmd_meas = meas; bus.cmd_sel = sel; bus.cmd_ac = acm; bus.cmd_len = len;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input int got_lat, input int want_lat,
                              input int cnt, input logic [1:0] sel, input logic ovf);
    exp_t e;
    checks++;
    if (got_lat !== want_lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, got_lat, want_lat);
    end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL %s_scoreboard got empty want entry", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (cnt < e.cmin || cnt > e.cmax) begin
        errors++; $display("FAIL %s_count got %0d want %0d..%0d", name, cnt, e.cmin, e.cmax);
      end
      checks++;
      if (sel !== e.sel) begin
        errors++; $display("FAIL %s_sel got %0d want %0d", name, sel, e.sel);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++; $display("FAIL %s_ovf got %0d want %0d", name, ovf, e.ovf);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ctl_main() !== 9'b0 || bus.cmd_ready !== 1'b1 || bus.result_valid !== 1'b0 ||
        bus.cmd_err !== 1'b0 || bus.result_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got ctl=%b rdy=%b vld=%b err=%b cnt=%0d want ctl=0 rdy=1 vld=0 err=0 cnt=0",
               ctl_main(), bus.cmd_ready, bus.result_valid, bus.cmd_err, bus.result_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus4.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b want 1/1", bus.cmd_ready, bus4.cmd_ready);
    end
  endtask

  task automatic test_measure();
    int vc = -1;
    exp_q.push_back('{sel: 2'd1, cmin: 12, cmax: 13, ovf: 1'b0});
    issue(1'b1, 2'd1, 1'b0, 24'd100);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (ctl_main() !== 9'b010100100) begin
          errors++; $display("FAIL meas_setup_ctl got %b want %b", ctl_main(), 9'b010100100);
        end
      end
      if (c == 5) begin
        checks++;
        if (ctl_main() !== 9'b010110100) begin
          errors++; $display("FAIL meas_arm_ctl got %b want %b", ctl_main(), 9'b010110100);
        end
      end
      if (c == 7) begin
        checks++;
        if (ctl_main() !== 9'b010111100) begin
          errors++; $display("FAIL meas_run_ctl got %b want %b", ctl_main(), 9'b010111100);
        end
      end
      if (bus.result_valid) begin vc = c; break; end
    end
    check_result("meas", vc, 109, int'(bus.result_count), bus.result_sel, bus.result_ovf);
    checks++;
    if (ctl_main() !== 9'b0) begin
      errors++; $display("FAIL meas_result_ctl got %b want 0", ctl_main());
    end
    bus.abort = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL abort_in_result got %b want 1", bus.result_valid);
    end
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.result_ack = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ack_wins got vld=%b rdy=%b want vld=0 rdy=1", bus.result_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_stress_ac();
    int rc = -1;
    int ac_bad = 0;
    int vseen = 0;
    logic exp_ac;
    issue(1'b0, 2'd2, 1'b1, 24'd10);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (ctl_main() !== 9'b001100010) begin
          errors++; $display("FAIL stress_setup_ctl got %b want %b", ctl_main(), 9'b001100010);
        end
      end
      exp_ac = (c >= 6 && c <= 15) ? (((c - 6) % 2) == 0) : 1'b0;
      if (ac !== exp_ac) ac_bad++;
      if (bus.result_valid) vseen++;
      if (bus.cmd_ready && rc < 0) begin
        rc = c;
        checks++;
        if (ctl_main() !== 9'b0) begin
          errors++; $display("FAIL stress_end_ctl got %b want 0", ctl_main());
        end
      end
    end
    checks++;
    if (ac_bad != 0) begin errors++; $display("FAIL stress_ac_clk got %0d bad cycles want 0", ac_bad); end
    checks++;
    if (rc != 16) begin errors++; $display("FAIL stress_ready_back got %0d want 16", rc); end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL stress_no_result got %0d want 0", vseen); end
  endtask

  task automatic test_len_zero();
    int rc = -1;
    issue(1'b0, 2'd0, 1'b0, 24'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (ctl_main() !== 9'b100111000) begin
          errors++; $display("FAIL len0_run_ctl got %b want %b", ctl_main(), 9'b100111000);
        end
      end
      if (bus.cmd_ready && rc < 0) rc = c;
    end
    checks++;
    if (rc != 7) begin errors++; $display("FAIL len0_ready_back got %0d want 7", rc); end
  endtask

  task automatic test_sel_reserved();
    int bad = 0;
    int errs = 0;
    issue(1'b1, 2'd3, 1'b0, 24'd10);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ctl_main() !== 9'b0 || bus.cmd_ready !== 1'b1) bad++;
      if (bus.cmd_err) errs++;
      if (c == 1) begin
        checks++;
        if (bus.cmd_err !== 1'b1) begin errors++; $display("FAIL sel3_err_pulse got %b want 1", bus.cmd_err); end
      end
    end
    checks++;
    if (errs != 1) begin errors++; $display("FAIL sel3_err_count got %0d want 1", errs); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sel3_quiet got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_abort();
    int rc = -1;
    int vseen = 0;
    issue(1'b1, 2'd0, 1'b0, 24'd50);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (ctl_main() !== 9'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_run got ctl=%b rdy=%b want ctl=0 rdy=1", ctl_main(), bus.cmd_ready);
    end
    issue(1'b0, 2'd1, 1'b0, 24'd3);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.result_valid) vseen++;
      if (bus.cmd_ready && rc < 0) rc = c;
    end
    checks++;
    if (rc != 9) begin errors++; $display("FAIL abort_next_cmd got %0d want 9", rc); end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL abort_no_result got %0d want 0", vseen); end
  endtask

  task automatic test_back_to_back();
    int vc;
    exp_q.push_back('{sel: 2'd0, cmin: 2, cmax: 2, ovf: 1'b0});
    exp_q.push_back('{sel: 2'd2, cmin: 3, cmax: 3, ovf: 1'b0});
    for (int k = 0; k < 2; k++) begin
      vc = -1;
      if (k == 0) issue(1'b1, 2'd0, 1'b0, 24'd16);
      else        issue(1'b1, 2'd2, 1'b0, 24'd24);
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (bus.result_valid) begin vc = c; break; end
      end
      check_result(k == 0 ? "b2b_a" : "b2b_b", vc, (k == 0) ? 25 : 33,
                   int'(bus.result_count), bus.result_sel, bus.result_ovf);
      bus.result_ack = 1'b1;
      @(negedge clk);
      bus.result_ack = 1'b0;
    end
  endtask

  task automatic test_overflow();
    int vc = -1;
    exp_q.push_back('{sel: 2'd0, cmin: 15, cmax: 15, ovf: 1'b1});
    @(negedge clk);
    bus4.cmd_meas = 1'b1; bus4.cmd_sel = 2'd0; bus4.cmd_ac = 1'b0; bus4.cmd_len = 24'd200;
    bus4.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus4.cmd_valid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus4.result_valid) begin vc = c; break; end
    end
    check_result("ovf", vc, 209, int'(bus4.result_count), bus4.result_sel, bus4.result_ovf);
    bus4.result_ack = 1'b1;
    @(negedge clk);
    bus4.result_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int vseen = 0;
    int nrdy = 0;
    issue(1'b1, 2'd2, 1'b0, 24'd100);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_main() !== 9'b0 || bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run got ctl=%b vld=%b rdy=%b want ctl=0 vld=0 rdy=1",
               ctl_main(), bus.result_valid, bus.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (bus.result_valid) vseen++;
      if (!bus.cmd_ready) nrdy++;
    end
    checks++;
    if (vseen != 0 || nrdy != 0) begin
      errors++; $display("FAIL reset_discard got vld_cycles=%0d busy_cycles=%0d want 0/0", vseen, nrdy);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_meas = 1'b0; bus.cmd_sel = 2'd0; bus.cmd_ac = 1'b0;
    bus.cmd_len = '0; bus.abort = 1'b0; bus.result_ack = 1'b0;
    bus4.cmd_valid = 1'b0; bus4.cmd_meas = 1'b0; bus4.cmd_sel = 2'd0; bus4.cmd_ac = 1'b0;
    bus4.cmd_len = '0; bus4.abort = 1'b0; bus4.result_ack = 1'b0;
    test_reset();
    test_measure();
    test_stress_ac();
    test_len_zero();
    test_sel_reserved();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odometer_seq_ctrl.md
# odometer_seq_ctrl

Sequencing controller for one stacked ring-oscillator odometer block (three selectable RVT stress chains plus their control logic). It accepts stress or measure commands from the test/scan controller and drives the block's power, enable, select, mode and AC-stress controls in a fixed safe order. In measure mode it counts synchronized rising edges of the block's OUT over a programmed window and returns a saturating count. It sits between the chip-level register interface and the odometer macro.

## Interface
- CNT_W, 16, width of edge counter / RESULT_COUNT
- LEN_W, 24, width of CMD_LEN (window or stress duration in CLK cycles)
- SETTLE, 4, CLK cycles of power/select settling before enabling the ring

- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  controller idle; command accepted when CMD_VALID & CMD_READY
- CMD_MEAS  in  1  1 = measure, 0 = stress
- CMD_SEL  in  2  ring: 0 = INV97, 1 = INV99, 2 = INV101, 3 = reserved (rejected)
- CMD_AC  in  1  stress type: 1 = AC (AC_STRESS_CLK toggles), 0 = DC
- CMD_LEN  in  LEN_W  duration in CLK cycles; 0 treated as 1
- ABORT  in  1  synchronous abort of any active command
- ROSC_OUT  in  1  OUT of odometer block, asynchronous to CLK
- SEL_INV97, SEL_INV99, SEL_INV101  out  1 each  one-hot ring select
- EN_POWER_ROSC, EN_ROSC, START, MEAS_STRESS, AC_DC, AC_STRESS_CLK  out  1 each  macro controls
- RESULT_VALID  out  1  count available; held until RESULT_ACK
- RESULT_ACK  in  1  consumes result
- RESULT_COUNT  out  CNT_W  edge count, saturating
- RESULT_SEL  out  2  ring the count belongs to
- RESULT_OVF  out  1  counter saturated
- CMD_ERR  out  1  one-cycle pulse on rejected command (CMD_SEL = 3)

## Operation
- States: IDLE, SETUP, ARM, RUN, DRAIN, RESULT.
- IDLE: CMD_READY = 1, all macro controls 0. Accepted CMD_SEL = 3 -> CMD_ERR pulse, stay IDLE. Otherwise latch command, -> SETUP.
- SETUP (SETTLE cycles): EN_POWER_ROSC = 1, selected SEL_INV* = 1 (exactly one), MEAS_STRESS = CMD_MEAS, AC_DC = CMD_AC & ~CMD_MEAS. -> ARM.
- ARM (1 cycle): EN_ROSC = 1 (held through RUN). Clear edge counter and duration counter. -> RUN.
- RUN (max(CMD_LEN,1) cycles): START = 1. Stress+AC: AC_STRESS_CLK = CLK/2 toggle, starting 1 on first RUN cycle. Measure: counter increments on each rising edge of 2-flop-synchronized ROSC_OUT; saturates at 2^CNT_W−1, sets OVF. At end: stress -> IDLE (all controls 0 same edge); measure -> DRAIN.
- DRAIN (3 cycles): START = 0, EN_ROSC = 0, power/select held; edges still in synchronizer are counted. -> RESULT.
- RESULT: RESULT_VALID = 1, COUNT/SEL/OVF stable; all macro controls 0. RESULT_ACK -> IDLE next cycle.
- ABORT in SETUP/ARM/RUN/DRAIN: next state IDLE, all controls 0, no result. ABORT in RESULT/IDLE ignored.
- ROSC_OUT edge rate must be below CLK/4; higher rates undercount (not detected).

## Timing
- Reset: state IDLE, CMD_READY = 1, all other outputs 0, counters 0.
- All outputs registered; CMD_READY low from cycle after acceptance.
- Measure latency accept -> RESULT_VALID = SETTLE + 1 + max(LEN,1) + 3 + 1 cycles.
- Stress: accept -> controls low after SETTLE + 1 + max(LEN,1) + 1 cycles.
- ABORT and RESULT_ACK same cycle in RESULT: ACK wins (IDLE).
- Reset mid-RUN: all controls drop asynchronously; result discarded.

## Test plan
- Measure, SEL=1, LEN=100, ROSC_OUT period 8 CLK -> SEL_INV99 only; RESULT_COUNT = 12 or 13, RESULT_SEL = 1, VALID at cycle 109 after accept.
- Stress AC, SEL=2, LEN=10 -> SEL_INV101, AC_DC=1, MEAS_STRESS=0, AC_STRESS_CLK toggles 10 cycles, no RESULT_VALID, CMD_READY back after 16 cycles.
- Measure, CNT_W=4, LEN=200, period 4 -> RESULT_COUNT = 15, RESULT_OVF = 1.
- CMD_SEL = 3 -> single CMD_ERR pulse, no control toggles, CMD_READY stays 1.
- ABORT 5 cycles into RUN -> all controls 0 next cycle, no result, new command accepted.
- RST_N low mid-RUN -> all outputs 0 immediately; CMD_READY = 1 after release.
